nf10_upb_interconnect_tx_framer: RTL and testbench

//  Parametrised TX framer for the inter-FPGA interconnect. Takes switch packets from the output queue (AXIS + tuser

---
 rtl/nf10_upb_interconnect_tx_framer.sv | 240 ++++++++++++++++++++++++
 tb/tb_nf10_upb_interconnect_tx_framer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_upb_interconnect_tx_framer.sv
// -----------------------------------------------------------------------------
// nf10_upb_interconnect_tx_framer
//
// TX framer for the inter-FPGA interconnect. Accepts switch packets from the
// output queue (AXI-Stream with tuser metadata). For each packet it emits one
// header beat carrying the metadata and then gearboxes every
// C_AXIS_DATA_WIDTH input beat down to C_LANE_WIDTH link beats. Packets are
// dropped while the link is down or when the advertised length is illegal.
//
// Optional feature macro: INTERCONNECT_FRAMER_STATS_EN
//   defined     -> pkt/drop/err statistics counters and byte-length check
//   not defined -> statistics outputs tied to zero; datapath identical
//
// Ports
//   axi_aclk, axi_resetn        clock, asynchronous active-low reset
//   s_axis_tdata/tkeep          packet data (byte 0 in [7:0]) and byte enables
//   s_axis_tuser_*              packet_length, in_port/in_vport, out_port/out_vport
//   s_axis_tvalid/tlast/tready  input AXIS handshake
//   link_up                     lane logic reports the channel is up
//   m_link_tdata/tkeep          link data and byte enables
//   m_link_tctrl                1 on the header beat
//   m_link_tvalid/tlast/tready  link handshake
//   pkt_count/drop_count/err_count  32-bit wrapping statistics
// -----------------------------------------------------------------------------
module nf10_upb_interconnect_tx_framer #(
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_LANE_WIDTH          = 64,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_INPORT_WIDTH        = 3,
  parameter int C_OUTPORT_WIDTH       = 8,
  parameter int C_MAX_PACKET_LENGTH   = 10000,
  parameter int C_LINK_ID             = 0
) (
  input  logic                               axi_aclk,
  input  logic                               axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_PACKET_LENGTH_WIDTH-1:0]   s_axis_tuser_packet_length,
  input  logic [C_INPORT_WIDTH-1:0]          s_axis_tuser_in_port,
  input  logic [C_INPORT_WIDTH-1:0]          s_axis_tuser_in_vport,
  input  logic [C_OUTPORT_WIDTH-1:0]         s_axis_tuser_out_port,
  input  logic [C_OUTPORT_WIDTH-1:0]         s_axis_tuser_out_vport,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  input  logic                               link_up,
  output logic [C_LANE_WIDTH-1:0]            m_link_tdata,
  output logic [C_LANE_WIDTH/8-1:0]          m_link_tkeep,
  output logic                               m_link_tctrl,
  output logic                               m_link_tvalid,
  output logic                               m_link_tlast,
  input  logic                               m_link_tready,
  output logic [31:0]                        pkt_count,
  output logic [31:0]                        drop_count,
  output logic [31:0]                        err_count
);

  localparam int R  = C_AXIS_DATA_WIDTH / C_LANE_WIDTH;
  localparam int LB = C_LANE_WIDTH / 8;
  localparam int SW = (R > 1) ? $clog2(R) : 1;
  localparam logic [31:0] MAX_LEN = 32'(C_MAX_PACKET_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DROP} state_t;

  state_t                             r_state, w_state_next;
  logic [C_PACKET_LENGTH_WIDTH-1:0]   r_len;
  logic [C_INPORT_WIDTH-1:0]          r_in_port, r_in_vport;
  logic [C_OUTPORT_WIDTH-1:0]         r_out_port, r_out_vport;
  logic [C_AXIS_DATA_WIDTH-1:0]       r_buf_data;
  logic [C_AXIS_DATA_WIDTH/8-1:0]     r_buf_keep;
  logic                               r_buf_last, r_buf_valid;
  logic [SW-1:0]                      r_slice;

  logic [31:0]   w_in_len32;
  logic          w_drop_pkt;
  logic [SW-1:0] w_last_slice;
  logic          w_at_last;
  logic          w_in_fire, w_out_fire;
  logic [63:0]   w_hdr;

  always_comb begin
    w_in_len32 = '0;
    w_in_len32[C_PACKET_LENGTH_WIDTH-1:0] = s_axis_tuser_packet_length;
  end

  assign w_drop_pkt = !link_up || (w_in_len32 == '0) || (w_in_len32 > MAX_LEN);
  assign w_in_fire  = s_axis_tvalid & s_axis_tready;
  assign w_out_fire = m_link_tvalid & m_link_tready;

  // Slice k is present iff its lowest byte is enabled (tkeep is LSB-contiguous),
  // so the last slice to send is the highest slice with byte 0 set.
  always_comb begin
    w_last_slice = '0;
    for (int i = 0; i < R; i++) begin
      if (r_buf_keep[i*LB]) w_last_slice = SW'(i);
    end
  end
  assign w_at_last = (r_slice == w_last_slice);

  // Header layout, all fields zero-extended into their byte lanes.
  always_comb begin
    w_hdr = '0;
    w_hdr[C_PACKET_LENGTH_WIDTH-1:0] = r_len;
    w_hdr[16 +: C_OUTPORT_WIDTH]     = r_out_port;
    w_hdr[24 +: C_INPORT_WIDTH]      = r_in_port;
    w_hdr[32 +: C_INPORT_WIDTH]      = r_in_vport;
    w_hdr[40 +: C_OUTPORT_WIDTH]     = r_out_vport;
    w_hdr[55:48]                     = 8'(C_LINK_ID);
    w_hdr[63:56]                     = 8'hFB;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= S_IDLE;
    else             r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_next  = r_state;
    s_axis_tready = 1'b0;
    m_link_tvalid = 1'b0;
    m_link_tdata  = '0;
    m_link_tkeep  = '0;
    m_link_tctrl  = 1'b0;
    m_link_tlast  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (s_axis_tvalid) w_state_next = w_drop_pkt ? S_DROP : S_HEADER;
      end
      S_HEADER: begin
        m_link_tvalid       = 1'b1;
        m_link_tctrl        = 1'b1;
        m_link_tkeep        = '1;
        m_link_tdata[63:0]  = w_hdr;
        if (m_link_tready) w_state_next = S_DATA;
      end
      S_DATA: begin
        // Refill on the same edge the last slice leaves, except once the
        // packet's tlast beat is buffered: the next packet waits for IDLE.
        s_axis_tready = !r_buf_valid | (m_link_tready & w_at_last & !r_buf_last);
        if (r_buf_valid) begin
          m_link_tvalid = 1'b1;
          m_link_tdata  = r_buf_data[int'(r_slice)*C_LANE_WIDTH +: C_LANE_WIDTH];
          m_link_tkeep  = r_buf_keep[int'(r_slice)*LB +: LB];
          m_link_tlast  = r_buf_last & w_at_last;
          if (m_link_tready && w_at_last && r_buf_last) w_state_next = S_IDLE;
        end
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_len       <= '0;
      r_in_port   <= '0;
      r_in_vport  <= '0;
      r_out_port  <= '0;
      r_out_vport <= '0;
      r_buf_keep  <= '0;
      r_buf_last  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_slice     <= '0;
    end else begin
      // link_up and the metadata are only looked at here, so changes during
      // a packet never affect it.
      if (r_state == S_IDLE && s_axis_tvalid && !w_drop_pkt) begin
        r_len       <= s_axis_tuser_packet_length;
        r_in_port   <= s_axis_tuser_in_port;
        r_in_vport  <= s_axis_tuser_in_vport;
        r_out_port  <= s_axis_tuser_out_port;
        r_out_vport <= s_axis_tuser_out_vport;
      end
      if (r_state == S_DATA) begin
        if (w_in_fire) begin
          r_buf_valid <= 1'b1;
          r_buf_keep  <= s_axis_tkeep;
          r_buf_last  <= s_axis_tlast;
          r_slice     <= '0;
        end else if (w_out_fire) begin
          if (w_at_last) r_buf_valid <= 1'b0;
          else           r_slice     <= r_slice + SW'(1);
        end
      end
    end
  end

  // NOTE: the payload buffer is a wide storage register with no reset; it is
  // only observed while r_buf_valid is set, which is itself reset.
  always_ff @(posedge axi_aclk) begin
    if (r_state == S_DATA && w_in_fire) r_buf_data <= s_axis_tdata;
  end

`ifdef INTERCONNECT_FRAMER_STATS_EN
  logic [31:0] r_byte_cnt, r_pkt_count, r_drop_count, r_err_count;
  logic [31:0] w_beat_bytes, w_total_bytes, w_lat_len32;

  always_comb begin
    w_lat_len32 = '0;
    w_lat_len32[C_PACKET_LENGTH_WIDTH-1:0] = r_len;
  end
  assign w_beat_bytes  = 32'($countones(s_axis_tkeep));
  assign w_total_bytes = r_byte_cnt + w_beat_bytes;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_byte_cnt   <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_err_count  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_byte_cnt <= '0;
      end else if (r_state == S_DATA && w_in_fire) begin
        r_byte_cnt <= w_total_bytes;
        // A length mismatch is only counted; the frame is still forwarded.
        if (s_axis_tlast && w_total_bytes != w_lat_len32) r_err_count <= r_err_count + 32'd1;
      end
      if (r_state == S_DATA && w_out_fire && m_link_tlast) r_pkt_count <= r_pkt_count + 32'd1;
      if (r_state == S_DROP && w_in_fire && s_axis_tlast) r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
  assign err_count  = r_err_count;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_nf10_upb_interconnect_tx_framer.sv
// -----------------------------------------------------------------------------
// Testbench for nf10_upb_interconnect_tx_framer (R = 4, 64-bit lane).
// A packet-level model turns each packet's byte array into the expected link
// stream (header word + 8-byte chunks) and the expected counter totals.
// -----------------------------------------------------------------------------
module tb_nf10_upb_interconnect_tx_framer;
  localparam int AXW = 256, LW = 64, PLW = 14, INW = 3, OUW = 8;
  localparam int MAXL = 10000, LINK_ID = 0;
  localparam int KB = AXW / 8, LB = LW / 8;
`ifdef INTERCONNECT_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            axi_aclk, axi_resetn;
  logic [AXW-1:0]  s_axis_tdata;
  logic [KB-1:0]   s_axis_tkeep;
  logic [PLW-1:0]  s_axis_tuser_packet_length;
  logic [INW-1:0]  s_axis_tuser_in_port, s_axis_tuser_in_vport;
  logic [OUW-1:0]  s_axis_tuser_out_port, s_axis_tuser_out_vport;
  logic            s_axis_tvalid, s_axis_tlast, s_axis_tready, link_up;
  logic [LW-1:0]   m_link_tdata;
  logic [LB-1:0]   m_link_tkeep;
  logic            m_link_tctrl, m_link_tvalid, m_link_tlast, m_link_tready;
  logic [31:0]     pkt_count, drop_count, err_count;

  nf10_upb_interconnect_tx_framer #(
    .C_AXIS_DATA_WIDTH(AXW), .C_LANE_WIDTH(LW), .C_PACKET_LENGTH_WIDTH(PLW),
    .C_INPORT_WIDTH(INW), .C_OUTPORT_WIDTH(OUW), .C_MAX_PACKET_LENGTH(MAXL),
    .C_LINK_ID(LINK_ID)
  ) u_dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser_packet_length(s_axis_tuser_packet_length),
    .s_axis_tuser_in_port(s_axis_tuser_in_port), .s_axis_tuser_in_vport(s_axis_tuser_in_vport),
    .s_axis_tuser_out_port(s_axis_tuser_out_port), .s_axis_tuser_out_vport(s_axis_tuser_out_vport),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .link_up(link_up),
    .m_link_tdata(m_link_tdata), .m_link_tkeep(m_link_tkeep), .m_link_tctrl(m_link_tctrl),
    .m_link_tvalid(m_link_tvalid), .m_link_tlast(m_link_tlast), .m_link_tready(m_link_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .err_count(err_count)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic          ctrl;
    logic          last;
    logic [LB-1:0] keep;
    logic [LW-1:0] data;
  } beat_t;

  typedef struct {
    logic       lu;
    int         nbytes;
    int         len;
    logic [7:0] op, ip, iv, ov;
    int         d_pkt, d_drop, d_err;
  } vec_t;

  beat_t exp_q[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0;
  int    exp_pkt = 0, exp_drop = 0, exp_err = 0;
  bit    mon_en = 1'b0, rdy_rand = 1'b0;
  int    hdr_cyc = 0, tlast_cyc = 0, hdr_gap = 0, start_cyc = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge axi_aclk) cyc++;

  always @(posedge axi_aclk) begin
    #1;
    if (rdy_rand) m_link_tready = ($urandom_range(0, 1) == 1);
  end

  // Link-side monitor: sampled mid-cycle, a fire here completes on the next edge.
  always @(negedge axi_aclk) begin : mon
    beat_t act, exp;
    if (mon_en) begin
      act = {m_link_tctrl, m_link_tlast, m_link_tkeep, m_link_tdata};
      if (prev_stall) check("link_hold_stable", {m_link_tvalid, act}, {1'b1, prev_beat});
      if (m_link_tvalid && exp_q.size() == 0) begin
        check("unexpected_link_valid", m_link_tvalid, 1'b0);
      end else if (m_link_tvalid && m_link_tready) begin
        exp = exp_q.pop_front();
        check("link_beat", act, exp);
        if (act.ctrl) begin
          hdr_gap = cyc - tlast_cyc;
          hdr_cyc = cyc;
        end
        if (act.last) tlast_cyc = cyc;
      end
      prev_stall = m_link_tvalid & !m_link_tready;
      prev_beat  = act;
    end
  end

  // Drives one packet and appends its expected link stream; returns the number
  // of cycles from tvalid rising to the acceptance of the tlast beat.
  task automatic send_pkt(input int nbytes, input int len, input logic lu,
                          input logic [7:0] op, input logic [7:0] ip,
                          input logic [7:0] iv, input logic [7:0] ov,
                          input bit use_model, output int cycles);
    byte unsigned pb[];
    logic [63:0]  hdr;
    int           nbeats;
    bit           dropped;
    pb = new[nbytes];
    foreach (pb[k]) pb[k] = 8'($urandom);
    dropped = !lu || len == 0 || len > MAXL;
    if (!dropped) begin
      hdr = 64'(len) + (64'(op) << 16) + (64'(ip % 8) << 24) + (64'(iv % 8) << 32)
          + (64'(ov) << 40) + (64'(LINK_ID % 256) << 48) + (64'hFB << 56);
      exp_q.push_back({1'b1, 1'b0, {LB{1'b1}}, hdr});
      for (int j = 0; j * LB < nbytes; j++) begin
        beat_t b;
        int    cnt;
        cnt    = (nbytes - j * LB < LB) ? nbytes - j * LB : LB;
        b      = '0;
        b.last = (j * LB + cnt == nbytes);
        b.keep = LB'((1 << cnt) - 1);
        for (int k = 0; k < cnt; k++) b.data[k*8 +: 8] = pb[j*LB + k];
        exp_q.push_back(b);
      end
    end
    if (use_model) begin
      if (dropped) exp_drop++;
      else begin
        exp_pkt++;
        if (nbytes != len) exp_err++;
      end
    end
    link_up                    = lu;
    s_axis_tuser_packet_length = PLW'(len);
    s_axis_tuser_out_port      = op;
    s_axis_tuser_in_port       = ip[INW-1:0];
    s_axis_tuser_in_vport      = iv[INW-1:0];
    s_axis_tuser_out_vport     = ov;
    nbeats    = (nbytes + KB - 1) / KB;
    cycles    = 0;
    start_cyc = cyc;
    for (int i = 0; i < nbeats; i++) begin
      int cnt, budget;
      bit acc;
      cnt          = (nbytes - i * KB < KB) ? nbytes - i * KB : KB;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      for (int k = 0; k < cnt; k++) begin
        s_axis_tdata[k*8 +: 8] = pb[i*KB + k];
        s_axis_tkeep[k]        = 1'b1;
      end
      s_axis_tlast  = (i == nbeats - 1);
      s_axis_tvalid = 1'b1;
      acc    = 1'b0;
      budget = 0;
      while (!acc) begin
        @(negedge axi_aclk);
        acc = s_axis_tready;
        @(posedge axi_aclk);
        #1;
        cycles++;
        budget++;
        if (!acc && budget > 2000) begin
          check("input_accept_timeout", s_axis_tready, 1'b1);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 10000) begin
      @(posedge axi_aclk);
      t++;
    end
    check("link_stream_drained", exp_q.size(), 0);
    repeat (3) @(posedge axi_aclk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, " pkt_count"},  pkt_count,  STATS ? 32'(exp_pkt)  : 32'd0);
    check({tag, " drop_count"}, drop_count, STATS ? 32'(exp_drop) : 32'd0);
    check({tag, " err_count"},  err_count,  STATS ? 32'(exp_err)  : 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int cyc_used;
    vecs[0] = '{1'b1,    64,    64, 8'h04, 8'h01, 8'h02, 8'h03, 1, 0, 0};
    vecs[1] = '{1'b1,    70,    70, 8'h11, 8'h05, 8'h06, 8'h07, 1, 0, 0};
    vecs[2] = '{1'b0,    96,    96, 8'h22, 8'h01, 8'h01, 8'h01, 0, 1, 0};
    vecs[3] = '{1'b1,    96, 10001, 8'h33, 8'h02, 8'h02, 8'h02, 0, 1, 0};
    vecs[4] = '{1'b1,    64,   100, 8'h44, 8'h03, 8'h04, 8'h55, 1, 0, 1};
    vecs[5] = '{1'b1,    32,     0, 8'h55, 8'h04, 8'h00, 8'h00, 0, 1, 0};
    vecs[6] = '{1'b1,     1,     1, 8'hA6, 8'h07, 8'h07, 8'hFF, 1, 0, 0};
    vecs[7] = '{1'b1, 10000, 10000, 8'h80, 8'h06, 8'h05, 8'h90, 1, 0, 0};
    vecs[8] = '{1'b1,    33,    33, 8'hFE, 8'h02, 8'h03, 8'h04, 1, 0, 0};

    axi_resetn = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser_packet_length = '0;
    s_axis_tuser_in_port = '0; s_axis_tuser_in_vport = '0;
    s_axis_tuser_out_port = '0; s_axis_tuser_out_vport = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; link_up = 1'b0; m_link_tready = 1'b0;

    #3;
    check("reset_outputs", {s_axis_tready, m_link_tvalid, m_link_tctrl, m_link_tlast,
                            m_link_tkeep, m_link_tdata}, '0);
    check("reset_counters", {pkt_count, drop_count, err_count}, '0);
    #19 axi_resetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    mon_en = 1'b1;

    // Table phase: each vector drained before the next one starts.
    rdy_rand = 1'b1;
    foreach (vecs[v]) begin
      send_pkt(vecs[v].nbytes, vecs[v].len, vecs[v].lu, vecs[v].op, vecs[v].ip,
               vecs[v].iv, vecs[v].ov, 1'b0, cyc_used);
      exp_pkt  += vecs[v].d_pkt;
      exp_drop += vecs[v].d_drop;
      exp_err  += vecs[v].d_err;
      if (vecs[v].d_drop != 0) begin
        // One IDLE cycle, then one DROP cycle per beat with tready high.
        check($sformatf("drop_cycles v%0d", v), cyc_used, (vecs[v].nbytes + KB - 1) / KB + 1);
        @(negedge axi_aclk);
        check($sformatf("drop_back_to_idle v%0d", v), s_axis_tready, 1'b0);
        @(posedge axi_aclk);
        #1;
      end
      wait_drain();
      check_counters($sformatf("vec%0d", v));
    end

    // Header one cycle after tvalid is seen in IDLE.
    rdy_rand = 1'b0;
    m_link_tready = 1'b1;
    send_pkt(48, 48, 1'b1, 8'h12, 8'h01, 8'h02, 8'h34, 1'b1, cyc_used);
    wait_drain();
    check("header_latency_from_idle", hdr_cyc - start_cyc, 1);

    // Back-to-back: next packet already valid when the tlast link beat leaves.
    send_pkt(64, 64, 1'b1, 8'h21, 8'h03, 8'h04, 8'h56, 1'b1, cyc_used);
    send_pkt(40, 40, 1'b1, 8'h22, 8'h05, 8'h06, 8'h78, 1'b1, cyc_used);
    wait_drain();
    check("header_gap_after_tlast", hdr_gap, 2);
    check_counters("back_to_back");

    // Randomised traffic with 50% link back-pressure.
    rdy_rand = 1'b1;
    for (int p = 0; p < 100; p++) begin
      int nb, ln;
      logic lu;
      nb = $urandom_range(1, 200);
      lu = ($urandom_range(0, 9) != 0);
      ln = ($urandom_range(0, 9) == 0) ? nb + $urandom_range(1, 5) : nb;
      send_pkt(nb, ln, lu, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, cyc_used);
    end
    wait_drain();
    check_counters("random");

    // Reset in the middle of DATA abandons the frame.
    rdy_rand = 1'b0;
    m_link_tready = 1'b1;
    mon_en = 1'b0;
    prev_stall = 1'b0;
    link_up = 1'b1;
    s_axis_tuser_packet_length = PLW'(128);
    for (int k = 0; k < KB / 4; k++) s_axis_tdata[k*32 +: 32] = $urandom;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("pre_reset_in_data", {m_link_tvalid, m_link_tctrl}, 2'b10);
    #2 axi_resetn = 1'b0;
    #1;
    check("midpkt_reset_outputs", {s_axis_tready, m_link_tvalid, m_link_tctrl, m_link_tlast,
                                   m_link_tkeep, m_link_tdata}, '0);
    check("midpkt_reset_counters", {pkt_count, drop_count, err_count}, '0);
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
    exp_q.delete();
    exp_pkt = 0; exp_drop = 0; exp_err = 0;
    repeat (2) @(posedge axi_aclk);
    #2 axi_resetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    mon_en = 1'b1;
    send_pkt(64, 64, 1'b1, 8'h04, 8'h01, 8'h02, 8'h03, 1'b1, cyc_used);
    wait_drain();
    check_counters("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
